// File: rtl/rv_uart_bridge.sv
// UART (8N1) host command bridge: 'W' adr dw -> bus write + ACK, 'R' adr -> bus read + 4 data bytes.
// Response begins within 3 clocks of bus acceptance or data capture; rdy low stalls the bus phase indefinitely.
module rv_uart_bridge #(
    parameter int BR      = 868,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic        rxd,
    output logic        txd,
    output logic [31:0] adr,
    output logic        cs,
    input  logic        rdy,
    output logic [3:0]  we,
    output logic        re,
    output logic [31:0] dw,
    input  logic [31:0] dr,
    output logic        busy,
    output logic        err
);
    localparam int CW = $clog2(BR + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BR - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BR / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
    typedef enum logic [1:0] {P_IDLE, P_ARG, P_BUS, P_RESP} p_st_t;

    rx_st_t        r_rx_st, w_rx_nxt;
    logic          r_rx_s1, r_rx_s2, r_rx_d;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic          w_rx_tick, w_rx_valid, w_rx_ferr;

    tx_st_t        r_tx_st, w_tx_nxt;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_sh;
    logic          r_hold_vld;
    logic [7:0]    r_hold_dat;
    logic          w_tx_tick, w_tx_load, w_hold_wr;

    p_st_t         r_p_st, w_p_nxt;
    logic          r_op_wr, r_rd_cap, r_err;
    logic [2:0]    r_idx, r_resp_cnt;
    logic [31:0]   r_adr, r_dw, r_resp;
    logic [TW-1:0] r_to_cnt;
    logic          w_cmd_ok, w_arg_last, w_timeout, w_abort, w_resp_done, w_err;

    // Receiver: counter holds the remaining clocks to the next sample point.
    assign w_rx_tick = (r_rx_cnt == '0);

    always_comb begin
        w_rx_nxt   = r_rx_st;
        w_rx_valid = 1'b0;
        w_rx_ferr  = 1'b0;
        case (r_rx_st)
            R_IDLE:  if (r_rx_d && !r_rx_s2) w_rx_nxt = R_START;
            R_START: if (w_rx_tick) w_rx_nxt = r_rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nxt = R_STOP;
            R_STOP: begin
                if (w_rx_tick) begin
                    w_rx_nxt   = R_IDLE;
                    w_rx_valid = r_rx_s2;
                    w_rx_ferr  = !r_rx_s2;
                end
            end
            default: w_rx_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_d   <= 1'b1;
            r_rx_st  <= R_IDLE;
            r_rx_cnt <= HALF_LAST;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            r_rx_st <= w_rx_nxt;
            if (r_rx_st == R_IDLE) begin
                r_rx_cnt <= HALF_LAST;
                r_rx_bit <= '0;
            end else if (w_rx_tick) begin
                r_rx_cnt <= BIT_LAST;
                if (r_rx_st == R_DATA) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - CW'(1);
            end
        end
    end

    // Transmitter: reloads straight from the holding register at the end of a stop bit.
    assign w_tx_tick = (r_tx_cnt == '0);

    always_comb begin
        w_tx_nxt  = r_tx_st;
        w_tx_load = 1'b0;
        case (r_tx_st)
            T_IDLE: begin
                if (r_hold_vld) begin
                    w_tx_nxt  = T_START;
                    w_tx_load = 1'b1;
                end
            end
            T_START: if (w_tx_tick) w_tx_nxt = T_DATA;
            T_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_nxt = T_STOP;
            T_STOP: begin
                if (w_tx_tick) begin
                    w_tx_nxt  = r_hold_vld ? T_START : T_IDLE;
                    w_tx_load = r_hold_vld;
                end
            end
            default: w_tx_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            r_tx_st    <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_hold_vld <= 1'b0;
            r_hold_dat <= '0;
        end else begin
            r_tx_st <= w_tx_nxt;
            if (w_tx_load) begin
                r_tx_sh  <= r_hold_dat;
                r_tx_cnt <= BIT_LAST;
                r_tx_bit <= '0;
            end else if (r_tx_st != T_IDLE) begin
                if (w_tx_tick) begin
                    r_tx_cnt <= BIT_LAST;
                    if (r_tx_st == T_DATA) begin
                        r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                        r_tx_bit <= r_tx_bit + 3'd1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt - CW'(1);
                end
            end
            if (w_tx_load) begin
                r_hold_vld <= 1'b0;
            end else if (w_hold_wr) begin
                r_hold_vld <= 1'b1;
                r_hold_dat <= r_resp[7:0];
            end
        end
    end

    assign txd = (r_tx_st == T_START) ? 1'b0 : (r_tx_st == T_DATA) ? r_tx_sh[0] : 1'b1;

    // Parser / bus master
    assign w_cmd_ok    = (r_rx_sh == 8'h57) || (r_rx_sh == 8'h52);
    assign w_arg_last  = (r_idx == (r_op_wr ? 3'd7 : 3'd3));
    assign w_timeout   = (r_p_st == P_ARG) && !w_rx_valid && (r_to_cnt == TO_LAST);
    assign w_abort     = w_timeout || ((r_p_st == P_ARG) && w_rx_ferr);
    assign w_hold_wr   = (r_p_st == P_RESP) && !r_rd_cap && (r_resp_cnt != 3'd0) && !r_hold_vld;
    assign w_resp_done = (r_resp_cnt == 3'd0) && !r_hold_vld && (r_tx_st == T_IDLE);
    assign w_err = w_rx_ferr || w_timeout
                || ((r_p_st == P_IDLE) && w_rx_valid && !w_cmd_ok)
                || (((r_p_st == P_BUS) || (r_p_st == P_RESP)) && w_rx_valid);

    always_comb begin
        w_p_nxt = r_p_st;
        case (r_p_st)
            P_IDLE: if (w_rx_valid) w_p_nxt = w_cmd_ok ? P_ARG : P_RESP;
            P_ARG: begin
                if (w_rx_valid && w_arg_last) w_p_nxt = P_BUS;
                else if (w_abort)             w_p_nxt = P_IDLE;
            end
            P_BUS:  if (rdy) w_p_nxt = P_RESP;
            P_RESP: if (w_resp_done) w_p_nxt = P_IDLE;
            default: w_p_nxt = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            r_p_st     <= P_IDLE;
            r_op_wr    <= 1'b0;
            r_rd_cap   <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_resp_cnt <= '0;
            r_adr      <= '0;
            r_dw       <= '0;
            r_resp     <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_p_st   <= w_p_nxt;
            r_err    <= w_err;
            r_to_cnt <= ((r_p_st != P_ARG) || w_rx_valid) ? '0 : r_to_cnt + TW'(1);
            case (r_p_st)
                P_IDLE: begin
                    if (w_rx_valid) begin
                        r_op_wr <= (r_rx_sh == 8'h57);
                        r_idx   <= '0;
                        if (!w_cmd_ok) begin
                            r_resp     <= 32'h15;
                            r_resp_cnt <= 3'd1;
                        end
                    end
                end
                P_ARG: begin
                    if (w_rx_valid) begin
                        r_idx <= r_idx + 3'd1;
                        if (!r_idx[2]) r_adr[{r_idx[1:0], 3'b000} +: 8] <= r_rx_sh;
                        else           r_dw[{r_idx[1:0], 3'b000} +: 8]  <= r_rx_sh;
                    end
                end
                P_BUS: begin
                    if (rdy) begin
                        r_resp_cnt <= r_op_wr ? 3'd1 : 3'd4;
                        r_resp     <= 32'h06;
                        r_rd_cap   <= !r_op_wr;
                    end
                end
                P_RESP: begin
                    if (r_rd_cap) begin
                        r_resp   <= dr;
                        r_rd_cap <= 1'b0;
                    end else if (w_hold_wr) begin
                        r_resp     <= {8'h00, r_resp[31:8]};
                        r_resp_cnt <= r_resp_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cs   = (r_p_st == P_BUS);
    assign we   = (cs && r_op_wr) ? 4'hF : 4'h0;
    assign re   = cs && !r_op_wr;
    assign adr  = r_adr;
    assign dw   = r_dw;
    assign busy = (r_p_st != P_IDLE);
    assign err  = r_err;
endmodule

// File: tb/tb_rv_uart_bridge.sv
// Directed bench for rv_uart_bridge: host-side UART driver, txd decoder and bus-side monitor.
module tb_rv_uart_bridge;
    localparam int BR      = 8;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        xreset, rxd, rdy;
    logic [31:0] dr;
    logic        txd, cs, re, busy, err;
    logic [3:0]  we;
    logic [31:0] adr, dw;

    rv_uart_bridge #(.BR(BR), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .xreset(xreset), .rxd(rxd), .txd(txd), .adr(adr), .cs(cs), .rdy(rdy),
        .we(we), .re(re), .dw(dw), .dr(dr), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int cs_cycles = 0, unstable = 0, err_cnt = 0, acc_cyc = 0, tx_stop_bad = 0;
    int cs0, e0;
    logic        cs_prev = 1'b0;
    logic [31:0] cap_adr, cap_dw;
    logic [3:0]  cap_we;
    logic        cap_re;
    logic [7:0]  txq[$];
    int          txs[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Bus-side monitor: values at cs rise, stability while cs held, acceptance cycle, err pulses.
    always @(negedge clk) begin
        if (cs) begin
            if (!cs_prev) begin
                cap_adr = adr; cap_dw = dw; cap_we = we; cap_re = re;
            end else if (adr !== cap_adr || dw !== cap_dw || we !== cap_we || re !== cap_re) begin
                unstable++;
            end
            cs_cycles++;
            if (rdy) acc_cyc = cyc;
        end
        cs_prev = cs;
        if (err) err_cnt++;
    end

    initial begin : tx_mon
        logic [7:0] b;
        int st;
        forever begin
            @(negedge txd);
            @(negedge clk);
            st = cyc;
            repeat (BR / 2 - 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BR) @(negedge clk);
                b[i] = txd;
            end
            repeat (BR) @(negedge clk);
            if (txd !== 1'b1) tx_stop_bad++;
            txq.push_back(b);
            txs.push_back(st);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qb(input int i);
        if (i < txq.size()) return txq[i];
        return 8'hxx;
    endfunction

    function automatic int qs(input int i);
        if (i < txs.size()) return txs[i];
        return -1000;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_b);
        rxd = 1'b0;
        repeat (BR) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BR) @(posedge clk);
            #1;
        end
        rxd = stop_b;
        repeat (BR) @(posedge clk);
        #1;
        rxd = 1'b1;
    endtask

    task automatic send_n(input logic [71:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(txq.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_cs(input int budget, input string tag);
        int k = 0;
        while (!cs && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, cs}, 32'd1);
    endtask

    task automatic mark();
        cs0 = cs_cycles;
        e0  = err_cnt;
        txq.delete();
        txs.delete();
    endtask

    initial begin
        xreset = 1'b0; rxd = 1'b1; rdy = 1'b1; dr = 32'h0;
        #3;
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_cs", {31'd0, cs}, 32'd0);
        chk("rst_we", {28'd0, we}, 32'd0);
        chk("rst_re", {31'd0, re}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_dw", dw, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 xreset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Write with rdy tied high
        mark();
        send_n(72'h57_10_00_00_80_EF_BE_AD_DE, 9);
        wait_tx(1, 400, "w_tx_wait");
        chk("w_busy_resp", {31'd0, busy}, 32'd1);
        chk("w_cs_cycles", 32'(cs_cycles - cs0), 32'd1);
        chk("w_adr", cap_adr, 32'h8000_0010);
        chk("w_dw", cap_dw, 32'hDEAD_BEEF);
        chk("w_we", {28'd0, cap_we}, 32'hF);
        chk("w_re", {31'd0, cap_re}, 32'd0);
        chk("w_ack", {24'd0, qb(0)}, 32'h06);
        chk("w_latency", 32'((qs(0) - acc_cyc) inside {[1:4]}), 32'd1);
        wait_idle(200, "w_busy_drop");
        chk("w_err", 32'(err_cnt - e0), 32'd0);

        // Read with 20-cycle stall; dr valid only in the cycle after acceptance
        mark();
        rdy = 1'b0; dr = 32'hAAAA_AAAA;
        send_n(72'h52_04_00_00_80, 5);
        wait_cs(40, "r_cs_wait");
        repeat (20) @(posedge clk);
        #1 rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0; dr = 32'h1234_5678;
        @(posedge clk);
        #1 dr = 32'hAAAA_AAAA;
        chk("r_cs_after", {31'd0, cs}, 32'd0);
        wait_tx(4, 600, "r_tx_wait");
        chk("r_unstable", 32'(unstable), 32'd0);
        chk("r_cs_len", 32'((cs_cycles - cs0) >= 20), 32'd1);
        chk("r_adr", cap_adr, 32'h8000_0004);
        chk("r_re", {31'd0, cap_re}, 32'd1);
        chk("r_we", {28'd0, cap_we}, 32'd0);
        chk("r_b0", {24'd0, qb(0)}, 32'h78);
        chk("r_b1", {24'd0, qb(1)}, 32'h56);
        chk("r_b2", {24'd0, qb(2)}, 32'h34);
        chk("r_b3", {24'd0, qb(3)}, 32'h12);
        chk("r_latency", 32'((qs(0) - acc_cyc) inside {[1:5]}), 32'd1);
        wait_idle(200, "r_busy_drop");

        // Bad opcode
        mark();
        rdy = 1'b1;
        send_n(72'h41, 1);
        wait_tx(1, 300, "nak_tx_wait");
        chk("nak_byte", {24'd0, qb(0)}, 32'h15);
        chk("nak_err", 32'(err_cnt - e0), 32'd1);
        chk("nak_no_cs", 32'(cs_cycles - cs0), 32'd0);
        wait_idle(200, "nak_busy_drop");

        // Argument timeout, then a normal read
        mark();
        send_n(72'h57_01, 2);
        chk("to_busy_arg", {31'd0, busy}, 32'd1);
        repeat (150) @(posedge clk);
        #1;
        chk("to_err", 32'(err_cnt - e0), 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_no_resp", 32'(txq.size()), 32'd0);
        chk("to_no_cs", 32'(cs_cycles - cs0), 32'd0);
        dr = 32'hCAFE_F00D;
        send_n(72'h52_00_00_00_00, 5);
        wait_tx(4, 600, "to_rd_wait");
        chk("to_rd_adr", cap_adr, 32'h0);
        chk("to_rd_b0", {24'd0, qb(0)}, 32'h0D);
        chk("to_rd_b3", {24'd0, qb(3)}, 32'hCA);
        wait_idle(200, "to_busy_drop");
        chk("to_err_after", 32'(err_cnt - e0), 32'd1);

        // Framing error mid-command, then a short glitch
        mark();
        send_n(72'h57, 1);
        send_byte(8'h33, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("fe_err", 32'(err_cnt - e0), 32'd1);
        chk("fe_busy", {31'd0, busy}, 32'd0);
        e0 = err_cnt;
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        chk("gl_err", 32'(err_cnt - e0), 32'd0);
        chk("gl_busy", {31'd0, busy}, 32'd0);
        chk("gl_no_tx", 32'(txq.size()), 32'd0);

        // Asynchronous reset while a write is stalled on rdy
        mark();
        rdy = 1'b0;
        send_n(72'h57_20_00_00_00_44_33_22_11, 9);
        wait_cs(40, "rs_cs_wait");
        repeat (3) @(negedge clk);
        chk("rs_we_before", {28'd0, we}, 32'hF);
        #1 xreset = 1'b0;
        #1;
        chk("rs_cs", {31'd0, cs}, 32'd0);
        chk("rs_we", {28'd0, we}, 32'd0);
        chk("rs_re", {31'd0, re}, 32'd0);
        chk("rs_txd", {31'd0, txd}, 32'd1);
        chk("rs_adr", adr, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 xreset = 1'b1; rdy = 1'b1; dr = 32'h0102_0304;
        repeat (4) @(posedge clk);
        #1;
        mark();
        send_n(72'h52_08_00_00_00, 5);
        wait_tx(4, 600, "rs_rd_wait");
        chk("rs_rd_adr", cap_adr, 32'h8);
        chk("rs_rd_b0", {24'd0, qb(0)}, 32'h04);
        chk("rs_rd_b1", {24'd0, qb(1)}, 32'h03);
        chk("rs_rd_b2", {24'd0, qb(2)}, 32'h02);
        chk("rs_rd_b3", {24'd0, qb(3)}, 32'h01);
        wait_idle(200, "rs_busy_drop");
        chk("tx_stop_bits", 32'(tx_stop_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_uart_bridge.md
Name: rv_uart_bridge

Overview:
- Serial-to-bus initiator. A host PC drives the on-chip bus over a UART link; the block's counterpart is the on-chip mini UART, which is a bus responder.
- Contains its own 8N1 receiver and transmitter, a binary command parser, and a single-outstanding bus master.
- Sits beside the rv32 core as a debug/loader port that writes and reads memory and registers while the core is held off.

Parameters:
- BR, 868, clocks per UART bit (≥4); the same value is used for rx and tx.
- TIMEOUT, 1000000, idle clocks allowed between bytes of one command before the command is aborted.

Ports:
- clk  in  1  clock.
- xreset  in  1  asynchronous active-low reset.
- rxd  in  1  serial in, idle high, asynchronous to clk.
- txd  out  1  serial out, idle high.
- adr  out  32  bus byte address.
- cs  out  1  bus request.
- rdy  in  1  bus ready; a transfer is accepted on a clk edge where cs && rdy.
- we  out  4  byte write enables.
- re  out  1  read strobe.
- dw  out  32  write data.
- dr  in  32  read data, valid in the cycle after acceptance.
- busy  out  1  high from the first command byte until the last response byte's stop bit ends.
- err  out  1  one-cycle pulse on any error event.

Behaviour:
- Reset (async, xreset=0):
  - txd=1; cs=0, we=0, re=0, adr=0, dw=0; busy=0, err=0.
  - All FSMs return to IDLE. An in-flight bus transfer or serial byte is abandoned immediately.
- RX, 8N1, LSB first:
  - rxd passes through a 2-FF synchronizer. A falling edge in R_IDLE loads the bit counter with BR/2.
  - At mid start bit: if the line is high, it is a false start and RX returns to R_IDLE silently.
  - Eight data bits are sampled every BR clocks, then the stop bit.
  - Stop=0 is a framing error: the byte is discarded, err pulses, and the parser returns to P_IDLE.
  - A good byte produces a one-cycle rx_valid with the byte.
- Parser states P_IDLE → P_ARG → P_BUS → P_RESP → P_IDLE:
  - P_IDLE, byte 0x57 'W': argument count = 8 (adr[7:0], adr[15:8], adr[23:16], adr[31:24], then dw in the same LE order).
  - P_IDLE, byte 0x52 'R': argument count = 4 (adr LE).
  - P_IDLE, any other byte: queue NAK 0x15, pulse err, go to P_RESP with 1 byte.
  - P_ARG: each rx_valid stores one byte and decrements the count. When the count reaches 0, go to P_BUS.
  - P_ARG timeout: a counter cleared on each byte; reaching TIMEOUT aborts to P_IDLE with an err pulse and no response.
  - P_BUS: drive cs=1, with we=4'hF for 'W' or re=1 for 'R'. Hold adr, dw, we and re stable until an edge where rdy=1. Clear cs/we/re on that edge. There is no bus timeout; rdy low stalls indefinitely.
  - After 'W' acceptance: queue ACK 0x06.
  - After 'R' acceptance: capture dr on the next edge, then queue dr[7:0], dr[15:8], dr[23:16], dr[31:24].
  - P_RESP: hand bytes to TX one at a time. Return to P_IDLE after the final stop bit completes.
  - adr is not aligned or modified; the responder ignores adr[1:0].
- Bytes received outside P_IDLE/P_ARG (during P_BUS or P_RESP) are dropped with an err pulse (overrun). They are not parsed.
- TX states T_IDLE, START, DATA(8), STOP:
  - Each state lasts BR clocks; txd = 0, then data LSB first, then 1.
  - A 1-byte holding register feeds TX. The parser loads it only while it is empty.
  - Back-to-back bytes have no idle gap beyond the single stop bit.
- Latencies:
  - The first response start-bit edge occurs ≤3 clocks after bus acceptance (write) or after dr capture (read).
  - A 'W' with rdy tied high: cs is high for exactly 1 cycle, starting ≤2 clocks after the last argument byte's rx_valid.
- Simultaneous events:
  - rx_valid coinciding with a timeout: the byte wins and the counter clears.
  - Framing error in P_ARG aborts the command exactly like a timeout.
  - err stays a single pulse even when multiple error causes coincide.

Test Plan:
- Write: BR=8, send 57 10 00 00 80 EF BE AD DE, rdy=1 → one cs cycle with adr=0x80000010, dw=0xDEADBEEF, we=F; then txd sends 0x06; busy then drops.
- Read stall: send 52 04 00 00 80, hold rdy=0 for 20 cycles with dr=0x12345678 after acceptance → cs, re and adr stay stable throughout; response bytes are 78 56 34 12.
- Bad opcode 0x41 → err pulse, txd sends 0x15, and no cs assertion at all.
- Timeout: TIMEOUT=100, send 57 01 then wait 150 clocks → err pulse, no response; next 52 00 00 00 00 completes normally.
- Framing/false start: inject a byte with stop=0 mid-command → err, command dropped. Inject a 2-clock rxd glitch → no rx_valid.
- Reset mid-transfer: deassert xreset while cs=1 with rdy=0 → cs, we, re go to 0 and txd goes to 1 asynchronously; the next command works.
